modn_wrap_monitor: RTL
======================

Name: modn_wrap_monitor

Overview:
- Downstream consumer of the 3-bit ripple mod-n counter output.
- The counter's outputs ripple asynchronously and glitch during transitions. This block resynchronises the count into the clk domain and filters transient values.
- It tracks the legal sequence 0..MAXV, emits a one-cycle wrap_tick on each MAXV->0 wrap and keeps a saturating wrap count.
- It flags illegal values and sequence skips for status logic.

Parameters:
- W, 3, width of sampled count.
- MAXV, 5, terminal (largest legal) count value; legal values 0..MAXV.
- STABLE, 2, consecutive matching synchronised samples required before a value is accepted; range 1..15.
- CW, 8, width of wrap_count.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- en  input  1  monitor enable; 0 suspends classification.
- err_clr  input  1  synchronous clear of sticky error flags.
- cnt_in  input  W  raw count from the upstream counter, asynchronous to clk.
- cnt_sync  output  W  filtered, accepted count.
- cnt_valid  output  1  at least one value accepted since reset.
- wrap_tick  output  1  one-cycle pulse per legal MAXV->0 wrap.
- wrap_count  output  CW  number of wraps, saturating.
- illegal  output  1  one-cycle pulse: accepted value > MAXV.
- seq_err  output  1  one-cycle pulse: accepted legal value is not the expected successor.
- err_sticky  output  1  latched OR of illegal and seq_err.

Behaviour:
- Reset (clr=0, async): all registers 0. Outputs cnt_sync=0, cnt_valid=0, wrap_tick=0, wrap_count=0, illegal=0, seq_err=0, err_sticky=0. FSM enters WAIT.
- Synchroniser: s1<=cnt_in, s2<=s1, s3<=s2 each edge. match = (s2==s3).
- Filter, run counter run (4 bits):
  - on !match: run<=0.
  - on match and run<STABLE-1: run++.
  - on match and run==STABLE-1: accept event, run<=STABLE.
  - on match and run==STABLE: hold; no further accepts.
- Accept latency: with cnt_in held from before edge 1, acceptance occurs at edge 3+STABLE (edge 5 for STABLE=2). Any s2 change restarts the count.
- On an accept, let v=s2 and p=cnt_sync: cnt_sync<=v and cnt_valid<=1.
- FSM states:
  - WAIT: on accept, go to TRACK; no classification, no pulses.
  - TRACK: each accept with v!=p is classified, with priority top to bottom:
    - v>MAXV: illegal pulse.
    - p==MAXV and v==0: wrap_tick pulse; wrap_count++ unless all ones (saturate, no wrap).
    - v==p+1 and p<MAXV: normal step, no pulse.
    - otherwise: seq_err pulse.
  - Accept with v==p: no action.
  - en=0: FSM forced to WAIT next edge. Sync, filter and cnt_sync keep running. Pulses are suppressed in the same cycle en=0 is sampled.
- After an illegal value, the next legal accept is classified against p = the illegal value.
  - Since p>MAXV, the only match is the "otherwise" branch, so that accept raises seq_err.
  - Exception: if it is v==0 and p!=MAXV, it still raises seq_err.
- Pulses: registered, high for exactly the one cycle following the accept edge.
- err_sticky:
  - set by illegal or seq_err; cleared by err_clr=1 at the next edge.
  - a new error in the same cycle as err_clr wins (err_sticky stays 1).
- Counter bits settling at different times only produce unequal s2/s3 samples, which reset run. Transients shorter than STABLE+1 cycles are never accepted.

Test Plan:
- Reset, then hold cnt_in=0 for 8 cycles:
  - cnt_valid rises at edge 5, cnt_sync=0.
  - no pulses; err_sticky=0.
- Step cnt_in 0,1,2,3,4,5,0,1, each held 10 cycles, en=1:
  - exactly one wrap_tick, one cycle after the 0 after 5 is accepted.
  - wrap_count=1; seq_err=0, illegal=0.
- Hold cnt_in=3, pulse it to 6 for 2 cycles, return to 3 (STABLE=2):
  - cnt_sync stays 3; no illegal.
- Hold cnt_in=6 for 10 cycles:
  - illegal pulses once; err_sticky=1.
  - then 0: seq_err pulses.
  - assert err_clr: err_sticky=0 next cycle.
  - assert err_clr with a simultaneous new seq_err: err_sticky stays 1.
- CW=2, run 5 full wrap cycles:
  - wrap_count reaches 3 and saturates.
  - wrap_tick pulses 5 times.
- en=0 while cnt_in jumps 2->5, then en=1 while cnt_in 5->0:
  - no seq_err; the first accept after en=1 resyncs.
  - the subsequent wrap is counted only after TRACK is entered.
- Drive clr low mid-sequence (cnt_sync=4):
  - all outputs 0 immediately.
  - after release, the next stable value re-accepts at edge 5 with no pulses.

Source files
------------

// File: rtl/modn_wrap_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : modn_wrap_monitor                                             |
// | Brief    : Resynchronises and debounces a rippling mod-n count, tracks   |
// |            the 0..MAXV sequence, reports wraps, illegal values and skips.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module modn_wrap_monitor #(
    parameter int W      = 3,
    parameter int MAXV   = 5,
    parameter int STABLE = 2,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic          err_clr,
    input  logic [W-1:0]  cnt_in,
    output logic [W-1:0]  cnt_sync,
    output logic          cnt_valid,
    output logic          wrap_tick,
    output logic [CW-1:0] wrap_count,
    output logic          illegal,
    output logic          seq_err,
    output logic          err_sticky
);

    // Filter run-length thresholds: accept on reaching c_RUN_LAST, then park.
    localparam logic [3:0]   c_RUN_LAST = 4'(STABLE - 1);
    localparam logic [3:0]   c_RUN_FULL = 4'(STABLE);
    localparam logic [W-1:0] c_MAXV     = W'(MAXV);

    localparam logic [0:0]   c_ST_WAIT  = 1'b0;
    localparam logic [0:0]   c_ST_TRACK = 1'b1;

    logic [W-1:0]  r_s1;
    logic [W-1:0]  r_s2;
    logic [W-1:0]  r_s3;
    logic [2:0]    r_fill;
    logic [3:0]    r_run;
    logic [0:0]    r_state;
    logic [W-1:0]  r_cnt_sync;
    logic          r_cnt_valid;
    logic          r_wrap_tick;
    logic [CW-1:0] r_wrap_count;
    logic          r_illegal;
    logic          r_seq_err;
    logic          r_err_sticky;

    logic          w_match;
    logic          w_accept;
    logic [W:0]    w_p_inc;
    logic          w_step_ok;
    logic [0:0]    w_state_nxt;
    logic          w_illegal;
    logic          w_seq_err;
    logic          w_wrap;

    // Three-flop synchroniser; r_fill marks which stages hold post-reset data
    // so the filter cannot accept the reset value of the pipeline itself.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_fill <= 3'b000;
        end else begin
            r_s1   <= cnt_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_fill <= {r_fill[1:0], 1'b1};
        end
    end

    assign w_match  = r_fill[2] && (r_s2 == r_s3);
    assign w_accept = w_match && (r_run == c_RUN_LAST);

    // Stability filter: count consecutive equal samples, accept once per run.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_run <= 4'd0;
        end else if (!w_match) begin
            r_run <= 4'd0;
        end else if (r_run < c_RUN_LAST) begin
            r_run <= r_run + 4'd1;
        end else if (r_run == c_RUN_LAST) begin
            r_run <= c_RUN_FULL;
        end
    end

    // Successor check done one bit wider so p == 2^W-1 cannot alias to 0.
    assign w_p_inc   = {1'b0, r_cnt_sync} + {{W{1'b0}}, 1'b1};
    assign w_step_ok = ({1'b0, r_s2} == w_p_inc) && (r_cnt_sync < c_MAXV);

    // Next state and classification of each accepted value against the last.
    always_comb begin
        w_state_nxt = r_state;
        w_illegal   = 1'b0;
        w_seq_err   = 1'b0;
        w_wrap      = 1'b0;
        if (!en) begin
            w_state_nxt = c_ST_WAIT;
        end else if (w_accept) begin
            if (r_state == c_ST_WAIT) begin
                w_state_nxt = c_ST_TRACK;
            end else if (r_s2 != r_cnt_sync) begin
                if (r_s2 > c_MAXV) begin
                    w_illegal = 1'b1;
                end else if ((r_cnt_sync == c_MAXV) && (r_s2 == '0)) begin
                    w_wrap = 1'b1;
                end else if (!w_step_ok) begin
                    w_seq_err = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= c_ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accepted count tracks the filter regardless of enable.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt_sync  <= '0;
            r_cnt_valid <= 1'b0;
        end else if (w_accept) begin
            r_cnt_sync  <= r_s2;
            r_cnt_valid <= 1'b1;
        end
    end

    // One-cycle status pulses, saturating wrap counter and sticky error.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wrap_tick  <= 1'b0;
            r_illegal    <= 1'b0;
            r_seq_err    <= 1'b0;
            r_wrap_count <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_wrap_tick  <= w_wrap;
            r_illegal    <= w_illegal;
            r_seq_err    <= w_seq_err;
            if (w_wrap && (r_wrap_count != {CW{1'b1}})) begin
                r_wrap_count <= r_wrap_count + CW'(1);
            end
            // A fresh error outranks a simultaneous clear.
            r_err_sticky <= w_illegal | w_seq_err | (r_err_sticky & ~err_clr);
        end
    end

    assign cnt_sync   = r_cnt_sync;
    assign cnt_valid  = r_cnt_valid;
    assign wrap_tick  = r_wrap_tick;
    assign wrap_count = r_wrap_count;
    assign illegal    = r_illegal;
    assign seq_err    = r_seq_err;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire
